// File: rtl/shift_source.sv
// shift_source: parallel word to serial strobe/bit stream for the shift port of the register block
module shift_source #(
  parameter int WIDTH = 4,
  parameter int GAP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] data,
  output logic             sl,
  output logic             il,
  output logic             sr,
  output logic             ir,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;
  state_t state;
  logic [WIDTH-1:0] sbuf;
  logic [WIDTH-1:0] nxt;
  logic dir_q;
  logic [4:0] cnt;
  logic [3:0] gcnt;
  assign nxt = dir_q ? sbuf >> 1 : sbuf << 1;
  // The done pulse is registered on the edge that returns to IDLE, so a start
  // sampled at the edge ending the done cycle is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sbuf <= '0;
      dir_q <= 1'b0;
      cnt <= '0;
      gcnt <= '0;
      {sl, il, sr, ir, busy, done} <= '0;
    end else begin
      {sl, il, sr, ir, done} <= '0;
      case (state)
        IDLE: if (start) begin
          sbuf <= data;
          dir_q <= dir;
          cnt <= 5'(WIDTH);
          state <= SHIFT;
          busy <= 1'b1;
          {sl, il, sr, ir} <= {!dir, !dir & data[WIDTH-1], dir, dir & data[0]};
        end
        SHIFT: begin
          sbuf <= nxt;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end else if (GAP > 0) begin
            state <= WAIT;
            gcnt <= 4'(GAP);
          end else
            {sl, il, sr, ir} <= {!dir_q, !dir_q & nxt[WIDTH-1], dir_q, dir_q & nxt[0]};
        end
        WAIT: if (gcnt == 4'd1) begin
          state <= SHIFT;
          {sl, il, sr, ir} <= {!dir_q, !dir_q & sbuf[WIDTH-1], dir_q, dir_q & sbuf[0]};
        end else
          gcnt <= gcnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_source.sv
// tb_shift_source: randomized and directed checks of shift_source against a timing-rule model
module tb_shift_source;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_v [3];
  logic dir_v [3];
  logic [3:0] data_v [3];
  wire [5:0] obs [3];
  logic [3:0] rg [2];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = g == 2 ? 1 : 4;
    localparam int G = g == 0 ? 0 : g == 1 ? 2 : 3;
    logic sl, il, sr, ir, busy, done;
    shift_source #(.WIDTH(W), .GAP(G)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .dir(dir_v[g]),
      .data(data_v[g][W-1:0]), .sl(sl), .il(il), .sr(sr), .ir(ir),
      .busy(busy), .done(done)
    );
    assign obs[g] = {sl, il, sr, ir, busy, done};
  end
  // downstream 4-bit register fed by the two WIDTH=4 sources
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (obs[k][5]) rg[k] <= {rg[k][2:0], obs[k][4]};
      else if (obs[k][3]) rg[k] <= {obs[k][2], rg[k][3:1]};
  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int wid(int i); return i == 2 ? 1 : 4; endfunction
  function automatic int gap(int i); return i == 0 ? 0 : i == 1 ? 2 : 3; endfunction
  // expected {sl,il,sr,ir,busy,done} in cycle c after the accepting edge
  function automatic logic [5:0] model(int w, int g, int c, logic d, logic [3:0] v);
    int per = g + 1;
    int last = (w - 1) * per + 1;
    int k;
    logic b;
    if (c <= last) begin
      if ((c - 1) % per != 0) return 6'b000010;
      k = (c - 1) / per;
      b = d ? v[k] : v[w-1-k];
      return d ? {2'b00, 1'b1, b, 2'b10} : {1'b1, b, 2'b00, 2'b10};
    end
    return c == last + 1 ? 6'b000001 : 6'b000000;
  endfunction
  task automatic xfer(int i, logic d, logic [3:0] v, bit hold, int abort_at);
    int w = wid(i);
    int g = gap(i);
    int last = (w - 1) * (g + 1) + 1;
    start_v[i] = 1'b1;
    dir_v[i] = d;
    data_v[i] = v;
    @(posedge clk);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      check($sformatf("u%0d_c%0d", i, c), obs[i], model(w, g, c, d, v));
      if (c == 1) begin
        start_v[i] = hold;
        dir_v[i] = 1'($urandom);
        data_v[i] = hold ? 4'b0000 : 4'($urandom);
      end
      if (i < 2 && c == last + 1) check($sformatf("reg%0d", i), rg[i], v);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("abort_u%0d", k), obs[k], 0);
        return;
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      dir_v[k] = 1'b0;
      data_v[k] = 4'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("reset_u%0d", k), obs[k], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b0, 4'b1011, 0, 0);
    xfer(0, 1'b1, 4'b0110, 0, 0);
    xfer(1, 1'b0, 4'b1111, 0, 0);
    xfer(0, 1'b0, 4'b1101, 1, 0);
    xfer(0, 1'b1, 4'b0011, 0, 0);
    xfer(2, 1'b1, 4'b0001, 0, 0);
    xfer(2, 1'b0, 4'b0001, 0, 0);
    xfer(0, 1'b0, 4'b1010, 0, 2);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold", obs[0], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", obs[0], 0);
    xfer(0, 1'b0, 4'b1001, 0, 0);
    repeat (30) begin
      int i = $urandom_range(2);
      xfer(i, 1'($urandom), 4'($urandom), 0, 0);
      repeat ($urandom_range(2)) begin
        @(negedge clk);
        check("idle", obs[i], 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
